// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if
//   Serial-input bundle for seq_detector_param.
//   master : drives in_valid, in, cnt_clr; observes out, match_cnt, state_o
//   slave  : the detector side
// Handshake: a bit on `in` is consumed on a rising clk edge only while
// in_valid is high; there is no back-pressure (the detector is always ready).
interface seq_detector_param_if #(
   parameter int CNT_W = 8,
   parameter int ST_W  = 2
);
   logic             in_valid;
   logic             in;
   logic             cnt_clr;
   logic             out;
   logic [CNT_W-1:0] match_cnt;
   logic [ST_W-1:0]  state_o;

   modport master (
      output in_valid, in, cnt_clr,
      input  out, match_cnt, state_o
   );

   modport slave (
      input  in_valid, in, cnt_clr,
      output out, match_cnt, state_o
   );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Parametrised serial pattern detector (KMP prefix automaton).
//   clk      : clock, rising edge
//   clr_n    : synchronous active-low reset
//   bus      : seq_detector_param_if.slave
//                in_valid/in : qualified serial bit
//                cnt_clr     : synchronous clear of match_cnt
//                out         : one-cycle match pulse (comb if MEALY, else registered)
//                match_cnt   : saturating match count
//                state_o     : matched-prefix length (debug)
//   PATTERN bit PAT_W-1 is the first bit received, bit 0 the last.
module seq_detector_param #(
   parameter int             PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
   parameter bit             OVERLAP = 1'b1,
   parameter bit             MEALY   = 1'b1,
   parameter int             CNT_W   = 8
) (
   input logic                 clk,
   input logic                 clr_n,
   seq_detector_param_if.slave bus
);
   localparam int ST_W = ($clog2(PAT_W) < 1) ? 1 : $clog2(PAT_W);
   localparam logic [ST_W-1:0]  LAST    = ST_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Longest k (< PAT_W) such that the first k pattern bits equal the last k
   // bits of (first s pattern bits followed by b). With s = PAT_W-1 and
   // b = PATTERN[0] this is the longest proper border of the pattern, so the
   // same table serves both the mismatch and the overlapping-match case.
   function automatic int kmp_next(input int s, input logic b);
      logic [PAT_W-1:0] seq;
      logic             ok;
      int               best;
      int               idx;
      seq  = '0;
      best = 0;
      for (int j = 0; j < PAT_W; j++) begin
         if (j < s)       seq[j] = PATTERN[PAT_W-1-j];
         else if (j == s) seq[j] = b;
      end
      for (int k = 1; k < PAT_W; k++) begin
         if (k <= s + 1) begin
            ok = 1'b1;
            for (int j = 0; j < PAT_W; j++) begin
               if (j < k) begin
                  idx = s + 1 - k + j;
                  if (seq[idx] != PATTERN[PAT_W-1-j]) ok = 1'b0;
               end
            end
            if (ok) best = k;
         end
      end
      return best;
   endfunction

   // Transition table, fixed at elaboration: one entry per (state, bit).
   logic [ST_W-1:0] nxt0 [PAT_W];
   logic [ST_W-1:0] nxt1 [PAT_W];

   for (genvar gs = 0; gs < PAT_W; gs++) begin : g_tab
      assign nxt0[gs] = ST_W'(kmp_next(gs, 1'b0));
      assign nxt1[gs] = ST_W'(kmp_next(gs, 1'b1));
   end

   logic [ST_W-1:0]  state_q, state_d;
   logic [ST_W-1:0]  nxt_on_bit;
   logic             match;
   logic [CNT_W-1:0] cnt_q;

   // State register
   always_ff @(posedge clk) begin
      if (!clr_n) state_q <= '0;
      else        state_q <= state_d;
   end

   // Next state and match term
   always_comb begin
      nxt_on_bit = '0;
      for (int s = 0; s < PAT_W; s++) begin
         if (state_q == ST_W'(s)) nxt_on_bit = bus.in ? nxt1[s] : nxt0[s];
      end

      match = bus.in_valid && (state_q == LAST) && (bus.in == PATTERN[0]);

      state_d = state_q;
      if (bus.in_valid) begin
         // Non-overlapping mode restarts from empty after a hit.
         if (match && !OVERLAP) state_d = '0;
         else                   state_d = nxt_on_bit;
      end
   end

   // Saturating match counter; cnt_clr beats a coincident increment.
   always_ff @(posedge clk) begin
      if (!clr_n)                         cnt_q <= '0;
      else if (bus.cnt_clr)               cnt_q <= '0;
      else if (match && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
   end

   if (MEALY) begin : g_mealy
      assign bus.out = clr_n & match;
   end else begin : g_moore
      logic out_q;
      always_ff @(posedge clk) begin
         if (!clr_n) out_q <= 1'b0;
         else        out_q <= match;
      end
      assign bus.out = out_q;
   end

   assign bus.match_cnt = cnt_q;
   assign bus.state_o   = state_q;
endmodule
